mskrnd_feeder: RTL and testbench
================================

# mskrnd_feeder

Fresh-randomness source for the masked datapath. It expands a 64-bit seed with a Galois LFSR into an `NRND`-bit random word per cycle. It serves the word over a valid/ready stream to the bank of masked AND gadgets, each bit feeding one gadget's `rnd` input. Every bit is served at most once: the LFSR advances only on a consume. After `RESEED_INTERVAL` consumed words the block stalls and requests a new seed.

## Interface
Parameters:
- `NRND`, 8, random bits produced per cycle (1..64).
- `WARM`, 4, warm-up cycles after each seed load, with no output (≥1).
- `RESEED_INTERVAL`, 1024, words served per seed (≥2).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `seed` in 64: seed value.
- `seed_valid` in 1: seed offered.
- `seed_ready` out 1: seed accepted when `seed_valid & seed_ready`.
- `reseed_req` out 1: block needs a seed.
- `rnd` out NRND: random word; forced to 0 when `rnd_valid`=0.
- `rnd_valid` out 1: word available.
- `rnd_ready` in 1: consumer takes word.

## Operation
- State: 64-bit `lfsr`, FSM, warm-up counter, consumed-word counter (`$clog2(RESEED_INTERVAL)` bits).
- LFSR step: `o = s[0]`; `s = (s >> 1) ^ (o ? 64'hD800_0000_0000_0000 : 0)`.
  - The mask encodes x^64+x^63+x^61+x^60+1.
  - One cycle advance = NRND unrolled steps. The step i output goes to `rnd[i]` (i=0 earliest).
  - `rnd` is derived combinationally from the current `lfsr` register, gated by `rnd_valid`.
- Seed load: `lfsr <= (seed==0) ? 64'h1 : seed`. A zero seed must never lock the LFSR.
- FSM states:
  - UNSEEDED (reset):
    - Outputs: `seed_ready`=1, `reseed_req`=1, `rnd_valid`=0.
    - Seed accepted → WARMUP.
  - WARMUP:
    - Outputs: `seed_ready`=0, `rnd_valid`=0.
    - The LFSR advances one cycle-step per cycle for WARM cycles, then → RUN.
  - RUN:
    - Outputs: `rnd_valid`=1, `seed_ready`=1, `reseed_req`=0.
    - On `rnd_ready`: LFSR advances and the counter increments.
    - When a consume hits count `RESEED_INTERVAL-1`: → RESEED_WAIT, counter cleared.
  - RESEED_WAIT:
    - Outputs identical to UNSEEDED.
    - Seed accepted → WARMUP.
- Simultaneous consume and seed accept in RUN:
  - The consumed word is the current (pre-seed) word.
  - The seed load takes priority over the LFSR advance.
  - Counter cleared, → WARMUP.
- `seed_valid` in WARMUP is ignored; no accept occurs.
- `rnd_ready` without `rnd_valid` has no effect.

## Timing
- Reset values: `lfsr`=0, counters=0, state UNSEEDED. Outputs: `rnd`=0, `rnd_valid`=0, `seed_ready`=1, `reseed_req`=1.
- Seed accepted at edge t → WARMUP during cycles t+1..t+WARM → `rnd_valid`=1 from cycle t+WARM+1.
  - Default WARM=4: valid 5 cycles after accept.
- Throughput: one word per cycle while `rnd_ready` is held high.
  - A word stays stable while `rnd_valid & ~rnd_ready`.
- `rnd_valid` falls in the cycle after the `RESEED_INTERVAL`-th consume.
- `rst_n` asserted mid-operation: all state returns to reset values immediately (asynchronous). No word is served until a new seed completes WARMUP.

## Structure
- Shared package `mskrnd_pkg`:
  - `LFSR_W`=64.
  - `LFSR_MASK`=64'hD800_0000_0000_0000.
  - `ZERO_SEED_SUB`=64'h1.
  - FSM state enum {UNSEEDED, WARMUP, RUN, RESEED_WAIT}.
- One sub-module, `mskrnd_lfsr_step`: purely combinational, NRND unrolled Galois steps, outputs {next_state, word}. It is used for both WARMUP and RUN advances.

## Test plan
- Reset then seed 64'h1 with NRND=8, WARM=4, `rnd_ready`=1:
  - `rnd_valid` rises 5 cycles after accept.
  - First four words: 8'h00, 8'h00, 8'h00, 8'hB0.
- Seed 64'h0: behaviour identical to seed 64'h1 (same word sequence).
- Backpressure: deassert `rnd_ready` for 3 cycles mid-stream → `rnd` holds its value. On release, the stream continues with no word skipped or repeated vs. the no-stall reference sequence.
- RESEED_INTERVAL=4, continuous consume:
  - After exactly 4 consumed words: `rnd_valid`=0, `reseed_req`=1, `seed_ready`=1.
  - A new seed yields `rnd_valid` again 5 cycles after accept.
- Seed offered in RUN in the same cycle as a consume:
  - The consumed word equals the pre-seed expected word.
  - `rnd_valid` drops next cycle, and the post-warm-up sequence matches the fresh-seed reference.
- `rst_n` pulsed low during WARMUP and during RUN → outputs return to reset values asynchronously, and the block waits in UNSEEDED.

Source files
------------

// File: rtl/mskrnd_pkg.sv
// Shared constants and types for the masked-randomness feeder.
package mskrnd_pkg;

  localparam int unsigned LFSR_W = 64;

  // Galois feedback mask for x^64 + x^63 + x^61 + x^60 + 1.
  localparam logic [LFSR_W-1:0] LFSR_MASK = 64'hD800_0000_0000_0000;

  // Loaded in place of an all-zero seed so the LFSR can never lock up.
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 64'h1;

  typedef enum logic [1:0] {
    UNSEEDED,
    WARMUP,
    RUN,
    RESEED_WAIT
  } state_e;

endpackage

// File: rtl/mskrnd_feeder_if.sv
// Seed and random-word streams between the feeder and its environment.
interface mskrnd_feeder_if #(
  parameter int unsigned NRND = 8
);

  logic [63:0]     seed;
  logic            seed_valid;
  logic            seed_ready;
  logic            reseed_req;
  logic [NRND-1:0] rnd;
  logic            rnd_valid;
  logic            rnd_ready;

  // Environment side: offers seeds, consumes random words.
  modport master (
    output seed, seed_valid, rnd_ready,
    input  seed_ready, reseed_req, rnd, rnd_valid
  );

  // Feeder side.
  modport slave (
    input  seed, seed_valid, rnd_ready,
    output seed_ready, reseed_req, rnd, rnd_valid
  );

endinterface

// File: rtl/mskrnd_lfsr_step.sv
// NRND unrolled Galois LFSR steps; step i output lands in word[i].
module mskrnd_lfsr_step
  import mskrnd_pkg::*;
#(
  parameter int unsigned NRND = 8
) (
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] next_state,
  output logic [NRND-1:0]   word
);

  logic [LFSR_W-1:0] s;

  // Shift out one bit per step, folding the mask back in when that bit is set.
  always_comb begin
    s    = cur;
    word = '0;
    for (int i = 0; i < int'(NRND); i++) begin
      word[i] = s[0];
      s       = (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
    end
    next_state = s;
  end

endmodule

// File: rtl/mskrnd_feeder.sv
// Fresh-randomness source: seeded LFSR served one word per consume,
// stalling for a new seed after RESEED_INTERVAL words.
module mskrnd_feeder
  import mskrnd_pkg::*;
#(
  parameter int unsigned NRND            = 8,
  parameter int unsigned WARM            = 4,
  parameter int unsigned RESEED_INTERVAL = 1024
) (
  input logic             clk,
  input logic             rst_n,
  mskrnd_feeder_if.slave  bus
);

  localparam int unsigned CntW  = (RESEED_INTERVAL > 1) ? $clog2(RESEED_INTERVAL) : 1;
  localparam int unsigned WarmW = (WARM > 1) ? $clog2(WARM) : 1;

  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [WarmW-1:0]  warm_q;
  logic [CntW-1:0]   cnt_q;
  logic              rnd_valid_q;
  logic              seed_ready_q;
  logic              reseed_req_q;

  logic [LFSR_W-1:0] step_next;
  logic [NRND-1:0]   step_word;
  logic [LFSR_W-1:0] seed_val;
  logic              seed_acc;
  logic              consume;

  mskrnd_lfsr_step #(
    .NRND (NRND)
  ) u_step (
    .cur        (lfsr_q),
    .next_state (step_next),
    .word       (step_word)
  );

  assign seed_val = (bus.seed == '0) ? ZERO_SEED_SUB : bus.seed;
  assign seed_acc = bus.seed_valid & seed_ready_q;
  assign consume  = rnd_valid_q & bus.rnd_ready;

  assign bus.rnd        = rnd_valid_q ? step_word : '0;
  assign bus.rnd_valid  = rnd_valid_q;
  assign bus.seed_ready = seed_ready_q;
  assign bus.reseed_req = reseed_req_q;

  // FSM, LFSR, counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNSEEDED;
      lfsr_q       <= '0;
      warm_q       <= '0;
      cnt_q        <= '0;
      rnd_valid_q  <= 1'b0;
      seed_ready_q <= 1'b1;
      reseed_req_q <= 1'b1;
    end else begin
      case (state_q)
        UNSEEDED, RESEED_WAIT: begin
          if (seed_acc) begin
            lfsr_q       <= seed_val;
            warm_q       <= '0;
            cnt_q        <= '0;
            state_q      <= WARMUP;
            seed_ready_q <= 1'b0;
            reseed_req_q <= 1'b0;
          end
        end
        WARMUP: begin
          lfsr_q <= step_next;
          if (warm_q == WarmW'(WARM - 1)) begin
            warm_q       <= '0;
            state_q      <= RUN;
            rnd_valid_q  <= 1'b1;
            seed_ready_q <= 1'b1;
          end else begin
            warm_q <= warm_q + 1'b1;
          end
        end
        RUN: begin
          // A seed accept wins over a same-cycle consume; the consumed word
          // is the one already on rnd, so nothing is lost.
          if (seed_acc) begin
            lfsr_q       <= seed_val;
            warm_q       <= '0;
            cnt_q        <= '0;
            state_q      <= WARMUP;
            rnd_valid_q  <= 1'b0;
            seed_ready_q <= 1'b0;
          end else if (consume) begin
            lfsr_q <= step_next;
            if (cnt_q == CntW'(RESEED_INTERVAL - 1)) begin
              cnt_q        <= '0;
              state_q      <= RESEED_WAIT;
              rnd_valid_q  <= 1'b0;
              reseed_req_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= UNSEEDED;
      endcase
    end
  end

endmodule

// File: tb/tb_mskrnd_feeder.sv
// Self-checking bench for mskrnd_feeder against a bit-serial LFSR stream model.
module tb_mskrnd_feeder;

  localparam int unsigned NRND = 8;
  localparam int unsigned WARM = 4;
  localparam int unsigned RI   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mskrnd_feeder_if #(.NRND(NRND)) bus ();

  mskrnd_feeder #(
    .NRND            (NRND),
    .WARM            (WARM),
    .RESEED_INTERVAL (RI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference generator: next unserved bit position of the seeded stream.
  logic [63:0] m_lfsr;
  logic [7:0]  first4 [4];

  function automatic logic [63:0] bit_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  function automatic logic [NRND-1:0] peek_word(input logic [63:0] s);
    logic [63:0]     t;
    logic [NRND-1:0] w;
    t = s;
    for (int i = 0; i < int'(NRND); i++) begin
      w[i] = t[0];
      t    = bit_step(t);
    end
    return w;
  endfunction

  task automatic model_advance();
    repeat (NRND) m_lfsr = bit_step(m_lfsr);
  endtask

  task automatic model_seed(input logic [63:0] s);
    m_lfsr = (s == 64'h0) ? 64'h1 : s;
    repeat (WARM * NRND) m_lfsr = bit_step(m_lfsr);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [NRND-1:0] obs, input logic [NRND-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_valid"}, bus.rnd_valid, 1'b0);
    chk1({tag, "_seed_ready"}, bus.seed_ready, 1'b1);
    chk1({tag, "_reseed_req"}, bus.reseed_req, 1'b1);
    chkw({tag, "_rnd"}, bus.rnd, '0);
  endtask

  // Called at a negedge; returns at the negedge of the first valid cycle.
  // With noise set, seed_valid/rnd_ready are waved during warm-up and must be ignored.
  task automatic load_seed(input logic [63:0] s, input bit noise);
    bus.seed       = s;
    bus.seed_valid = 1'b1;
    chk1("seed_ready_at_offer", bus.seed_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.seed       = ~s;
    bus.seed_valid = noise;
    bus.rnd_ready  = noise;
    for (int k = 1; k <= int'(WARM); k++) begin
      if (k > 1) @(negedge clk);
      chk1("warm_valid", bus.rnd_valid, 1'b0);
      chk1("warm_seed_ready", bus.seed_ready, 1'b0);
      chkw("warm_rnd", bus.rnd, '0);
      if (k == int'(WARM)) begin
        bus.seed_valid = 1'b0;
        bus.rnd_ready  = 1'b0;
      end
    end
    @(negedge clk);
    chk1("valid_after_warm", bus.rnd_valid, 1'b1);
    chk1("run_reseed_req", bus.reseed_req, 1'b0);
    model_seed(s);
  endtask

  // Consume n words with rnd_ready dropped stall_pct percent of cycles.
  task automatic serve(input int n, input int stall_pct);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 200) begin
      bus.rnd_ready = (int'($urandom_range(99)) >= stall_pct);
      chk1("run_valid", bus.rnd_valid, 1'b1);
      chkw("run_word", bus.rnd, peek_word(m_lfsr));
      @(posedge clk);
      if (bus.rnd_ready) begin
        model_advance();
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.rnd_ready = 1'b0;
    if (got < n) begin
      n_checks++;
      n_errors++;
      $error("FAIL serve_timeout: observed %0d words expected %0d", got, n);
    end
  endtask

  task automatic check_first4(input string tag);
    bus.rnd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chkw(tag, bus.rnd, first4[i]);
      @(posedge clk);
      @(negedge clk);
    end
    // rnd_ready held into RESEED_WAIT must do nothing.
    repeat (2) begin
      chk_idle({tag, "_after"});
      @(negedge clk);
    end
    bus.rnd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] s_a;
    logic [63:0] s_b;
    first4         = '{8'h00, 8'h00, 8'h00, 8'hB0};
    bus.seed       = '0;
    bus.seed_valid = 1'b0;
    bus.rnd_ready  = 1'b0;
    rst_n          = 1'b0;

    #12;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("unseeded");

    // Known-answer stream from seed 1, then seed 0 (with warm-up noise).
    load_seed(64'h1, 1'b0);
    check_first4("seed1_word");
    load_seed(64'h0, 1'b1);
    check_first4("seed0_word");

    // Directed three-cycle backpressure in mid-stream.
    load_seed({$urandom, $urandom}, 1'b0);
    serve(1, 0);
    bus.rnd_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk1("stall_valid", bus.rnd_valid, 1'b1);
      chkw("stall_word", bus.rnd, peek_word(m_lfsr));
      @(posedge clk);
      @(negedge clk);
    end
    serve(3, 0);
    chk_idle("interval_end");

    // Seed accepted in the same cycle as a consume.
    s_a = {$urandom, $urandom};
    s_b = {$urandom, $urandom};
    load_seed(s_a, 1'b0);
    serve(2, 0);
    chkw("pre_seed_word", bus.rnd, peek_word(m_lfsr));
    bus.rnd_ready = 1'b1;
    load_seed(s_b, 1'b0);
    serve(int'(RI), 0);
    chk_idle("after_reseed_in_run");

    // Asynchronous reset during warm-up.
    bus.seed       = {$urandom, $urandom};
    bus.seed_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.seed_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle("rst_warmup");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WARM + 2) begin
      @(negedge clk);
      chk_idle("wait_after_rst_warmup");
    end

    // Asynchronous reset during RUN, then a fresh seed gets a full interval.
    load_seed({$urandom, $urandom}, 1'b0);
    serve(2, 0);
    #2 rst_n = 1'b0;
    #1 chk_idle("rst_run");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle("wait_after_rst_run");
    end
    load_seed({$urandom, $urandom}, 1'b0);
    serve(int'(RI), 0);
    chk_idle("post_rst_interval");

    // Randomized seeds and stall patterns.
    for (int it = 0; it < 6; it++) begin
      load_seed({$urandom, $urandom}, it[0]);
      serve(int'(RI), 40);
      chk_idle("rand_interval_end");
      repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
